// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding request to instruction memory, a
// single registered instruction slot, branch redirects and sticky fault reporting.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;

    logic xfer;
    logic waiting;
    logic timeout_hit;
    logic consume;

    assign imem_req    = (state_q == RUN) && rst_n && (!valid_q || !stall) && !branch_taken;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign fault       = (state_q == FAULT);
    assign fault_code  = code_q;

    assign xfer        = imem_req && imem_ready;
    assign waiting     = imem_req && !imem_ready;
    assign timeout_hit = waiting && (cnt_q == CNT_LAST);
    assign consume     = valid_q && !stall;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        code_d   = code_q;
        cnt_d    = 8'd0;

        if (state_q == RUN) begin
            // Branch outranks stall and any response arriving this cycle.
            if (branch_taken) begin
                valid_d = 1'b0;
                if (branch_target[1:0] == 2'b00) begin
                    pc_d = branch_target;
                end else begin
                    state_d = FAULT;
                    code_d  = 2'b01;
                end
            end else if (xfer) begin
                instr_d  = imem_rdata;
                pc_out_d = pc_q;
                valid_d  = 1'b1;
                pc_d     = pc_q + 32'd4;
            end else if (timeout_hit) begin
                state_d = FAULT;
                code_d  = 2'b10;
                valid_d = 1'b0;
            end else begin
                if (consume) begin
                    valid_d = 1'b0;
                end
                if (waiting) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
            valid_q  <= 1'b0;
            code_q   <= 2'b00;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns the word address as data.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fault;
    logic [1:0]  fault_code;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr;

    fetch_unit #(
        .RESET_PC(32'h00000000),
        .TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        $display("check %-16s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    // Advance one clock edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_ready    = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;

        tick();
        tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_code", 32'(fault_code), 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pcout", pc_out, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Streaming fetch with memory always ready
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        tick();
        chk("s0_instr", instruction, 32'h0);
        chk("s0_valid", 32'(instr_valid), 32'd1);
        tick();
        chk("s1_instr", instruction, 32'h4);
        chk("s1_pcout", pc_out, 32'h4);
        tick();
        chk("s2_instr", instruction, 32'h8);
        chk("s2_pcout", pc_out, 32'h8);
        chk("s2_valid", 32'(instr_valid), 32'd1);

        // Three stalled cycles hold the slot and suppress requests
        stall = 1'b1;
        #1;
        chk("stall_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", instruction, 32'h8);
            chk("stall_pcout", pc_out, 32'h8);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        #1;
        chk("rel_addr", imem_addr, 32'hC);
        tick();
        chk("rel_instr", instruction, 32'hC);
        chk("rel_pcout", pc_out, 32'hC);

        // Branch coinciding with the response for 0x10
        chk("pre_br_addr", imem_addr, 32'h10);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        chk("br_req", 32'(imem_req), 32'd0);
        tick();
        branch_taken = 1'b0;
        chk("br_valid", 32'(instr_valid), 32'd0);
        chk("br_addr", imem_addr, 32'h100);
        chk("br_instr_hold", instruction, 32'hC);
        tick();
        chk("br_instr", instruction, 32'h100);
        chk("br_pcout", pc_out, 32'h100);

        // Consume with no response clears valid
        imem_ready = 1'b0;
        tick();
        chk("consume_valid", 32'(instr_valid), 32'd0);

        // PC wrap at the top of the address space
        imem_ready    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'hFFFFFFFC;
        tick();
        branch_taken = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFFFFFC);
        tick();
        chk("wr_pcout", pc_out, 32'hFFFFFFFC);
        chk("wr_next_addr", imem_addr, 32'h0);
        chk("wr_fault", 32'(fault), 32'd0);
        tick();
        chk("wr_pcout0", pc_out, 32'h0);
        chk("wr_fault2", 32'(fault), 32'd0);

        // Timeout: 16 request cycles without ready
        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("to_fault_pre", 32'(fault), 32'd0);
        chk("to_req_pre", 32'(imem_req), 32'd1);
        tick();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_code", 32'(fault_code), 32'd2);
        chk("to_valid", 32'(instr_valid), 32'd0);
        chk("to_req", 32'(imem_req), 32'd0);

        // One-cycle reset recovers and restarts at RESET_PC
        rst_n = 1'b0;
        tick();
        chk("rr_fault", 32'(fault), 32'd0);
        chk("rr_code", 32'(fault_code), 32'd0);
        chk("rr_addr", imem_addr, 32'h0);
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        #1;
        chk("rr_req", 32'(imem_req), 32'd1);
        tick();
        chk("rr_pcout", pc_out, 32'h0);
        chk("rr_valid", 32'(instr_valid), 32'd1);

        // Misaligned branch faults; later branches are ignored
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        tick();
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_code", 32'(fault_code), 32'd1);
        chk("mis_valid", 32'(instr_valid), 32'd0);
        chk("mis_addr", imem_addr, 32'h4);
        branch_target = 32'h200;
        #1;
        chk("mis_req", 32'(imem_req), 32'd0);
        tick();
        branch_taken = 1'b0;
        #1;
        chk("fb_addr", imem_addr, 32'h4);
        chk("fb_fault", 32'(fault), 32'd1);
        chk("fb_code", 32'(fault_code), 32'd1);
        chk("fb_req", 32'(imem_req), 32'd0);
        chk("fb_pcout", pc_out, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports are named clk and rst_n.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000: PC loaded on reset; bits [1:0] are zero.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: maximum cycles imem_req may be held without imem_ready; range 2..255.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 imem_req  output  1  instruction memory request; the transfer completes on any cycle with imem_req and imem_ready both high.
REQ-007 imem_addr  output  32  word-aligned fetch address; equals the internal PC.
REQ-008 imem_ready  input  1  imem_rdata valid this cycle.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 instruction  output  32  registered instruction presented to the control decoder.
REQ-011 pc_out  output  32  address of the instruction currently presented.
REQ-012 instr_valid  output  1  instruction/pc_out hold a valid, unconsumed instruction.
REQ-013 stall  input  1  downstream hold; an instruction is consumed on any cycle with instr_valid=1 and stall=0.
REQ-014 branch_taken  input  1  redirect request, single cycle.
REQ-015 branch_target  input  32  redirect address, sampled when branch_taken=1.
REQ-016 fault  output  1  sticky; fetch halted.
REQ-017 fault_code  output  2  fault cause: 01 = misaligned target, 10 = timeout, 00 = none.

Function
REQ-018 The FSM SHALL have two states, RUN and FAULT; reset enters RUN; FAULT is left only by reset.
REQ-019 imem_req SHALL equal (state==RUN) && rst_n && (!instr_valid || !stall) && !branch_taken.
REQ-020 On a completed transfer with no branch: instruction<=imem_rdata, pc_out<=PC, instr_valid<=1, PC<=PC+4, all on the same edge; fetch-to-valid latency SHALL be 1 cycle after imem_ready.
REQ-021 PC+4 SHALL wrap modulo 2^32: 32'hFFFFFFFC advances to 32'h00000000 with no fault.
REQ-022 If instr_valid=1 and stall=1, instruction, pc_out and instr_valid SHALL hold, and no request is issued.
REQ-023 If the instruction is consumed with no new transfer completing, instr_valid SHALL clear on the next edge.
REQ-024 A consume and a transfer in the same cycle SHALL replace the instruction back-to-back, sustaining one instruction per cycle.
REQ-025 If branch_taken=1 and branch_target[1:0]==0: PC<=branch_target and instr_valid<=0; imem_rdata that cycle is ignored. Branch takes priority over stall and over imem_ready.
REQ-026 If branch_taken=1 and branch_target[1:0]!=0: state<=FAULT, fault_code<=01, instr_valid<=0, and PC is unchanged.
REQ-027 The timeout counter SHALL increment each cycle imem_req=1 and imem_ready=0, and clear on any completed transfer, on branch, or when imem_req=0.
REQ-028 When the counter reaches TIMEOUT-1 with imem_ready still 0: state<=FAULT, fault_code<=10, and instr_valid<=0.
REQ-029 In FAULT: imem_req=0; PC, instruction and pc_out hold; instr_valid=0; branch_taken is ignored; fault=1.
REQ-030 If misalignment and timeout occur in the same cycle, fault_code SHALL be 01.

Reset
REQ-031 While rst_n=0 at an edge, the block SHALL set: PC=RESET_PC, instruction=0, pc_out=0, instr_valid=0, fault=0, fault_code=00, counter=0, state=RUN.
REQ-032 imem_req SHALL be 0 during any cycle where rst_n=0.
REQ-033 Reset mid-operation SHALL discard any response in flight that cycle.
REQ-034 The first request SHALL be issued in the first cycle with rst_n=1.

Verification
REQ-035 Reset release with imem_ready tied 1 and rdata=addr: instruction=0,4,8,... with pc_out matching, instr_valid continuously 1 from cycle 2.
REQ-036 Stall high for 3 cycles while instr_valid=1 at pc_out=0x8: instruction and pc_out hold, imem_req=0; after release the next instruction from 0xC appears one cycle later.
REQ-037 branch_taken with target 0x100 in the same cycle as imem_ready for 0x10: the 0x10 word is never presented; next pc_out=0x100.
REQ-038 branch_target=0x102: fault=1 and fault_code=01 next cycle, imem_req=0 thereafter; a later valid branch is ignored.
REQ-039 imem_ready held 0 with TIMEOUT=16: fault_code=10 after exactly 16 request cycles; rst_n low for one cycle clears fault and fetch restarts at RESET_PC.
REQ-040 PC at 0xFFFFFFFC with imem_ready=1: the next imem_addr is 0x00000000 and fault stays 0.
